// File: rtl/proctypes.sv
// Shared processor types for the fetch/decode slice.
// Instruction, address and fetch handshake definitions.
package proctypes;

   localparam int INSTRUCTION_WIDTH = 32;
   localparam int ADDR_WIDTH        = 32;
   localparam int OPCODE_WIDTH      = 4;
   localparam int DECODE_DEPTH      = 8;

   typedef logic [INSTRUCTION_WIDTH-1:0] Instruction;
   typedef logic [ADDR_WIDTH-1:0]        InstructionAddr;

   typedef enum logic {
      fetchDequeue = 1'b0,
      fetchHold    = 1'b1
   } FetchAction;

   typedef enum logic [1:0] {
      DS_RUN,
      DS_COOL,
      DS_DRAIN,
      DS_DONE
   } DecodeState;

   typedef struct packed {
      InstructionAddr pc;
      Instruction     inst;
   } fifo_entry_t;

   // An all-zero word marks the end of the program.
   function automatic logic is_eop(Instruction i);
      return i == '0;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head entry.
// Push while full succeeds only together with a pop.
module sync_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_nxt;
   logic [CW-1:0]    count_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic             do_push;
   logic             do_pop;

   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;

   // Qualify requests and precompute the head for next cycle.
   always_comb begin
      do_pop    = pop && !empty;
      do_push   = push && (!full || do_pop);
      rd_nxt    = rd_ptr + AW'(do_pop);
      count_nxt = count + CW'(do_push) - CW'(do_pop);
      head_nxt  = rdata;
      if (count_nxt != '0) begin
         if (count == CW'(do_pop))
            head_nxt = wdata;
         else
            head_nxt = mem[rd_nxt];
      end
   end

   // Storage array; stale contents are hidden by the pointers.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   // Pointers, occupancy and registered head.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         rd_ptr <= rd_nxt;
         wr_ptr <= wr_ptr + AW'(do_push);
         count  <= count_nxt;
         rdata  <= head_nxt;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: buffers fetched beats and paces fetch.
// Splits the head instruction into opcode and operand.
module decode_stage
   import proctypes::*;
#(
   parameter int DEPTH    = DECODE_DEPTH,
   parameter int COOLDOWN = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   output FetchAction             action,
   input  logic                   instruction_valid,
   input  InstructionAddr         pc_in,
   input  Instruction             inst,
   output logic                   out_valid,
   input  logic                   out_ready,
   output InstructionAddr         out_pc,
   output logic [OPCODE_WIDTH-1:0] out_opcode,
   output logic [INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0] out_operand,
   output logic                   program_done,
   output logic                   overflow_err
);

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int CDW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   fifo_entry_t    wr_entry;
   fifo_entry_t    head;
   logic           push_req;
   logic           pop;
   logic           full;
   logic           empty;
   logic [CW-1:0]  count;
   logic           eop;
   DecodeState     state;
   DecodeState     state_nxt;
   logic [CDW-1:0] cool;
   logic [CDW-1:0] cool_nxt;

   assign wr_entry = '{pc: pc_in, inst: inst};
   assign push_req = instruction_valid && !is_eop(inst);
   assign out_valid = !empty;
   assign pop = out_valid && out_ready;

   assign out_pc      = head.pc;
   assign out_opcode  = head.inst[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
   assign out_operand = head.inst[INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0];

   sync_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Sticky drop flag and end-of-program marker.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_err <= 1'b0;
         eop          <= 1'b0;
      end else begin
         if (push_req && full && !pop)
            overflow_err <= 1'b1;
         if (instruction_valid && is_eop(inst))
            eop <= 1'b1;
      end
   end

   // Fetch pacing state and cooldown counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DS_RUN;
         cool  <= '0;
      end else begin
         state <= state_nxt;
         cool  <= cool_nxt;
      end
   end

   // Next state, fetch request and completion flag.
   always_comb begin
      state_nxt    = state;
      cool_nxt     = cool;
      action       = fetchHold;
      program_done = 1'b0;
      unique case (state)
         DS_RUN: begin
            if (!rst && !eop && count <= CW'(DEPTH - 4)) begin
               action    = fetchDequeue;
               state_nxt = DS_COOL;
               cool_nxt  = CDW'(COOLDOWN - 1);
            end
         end
         DS_COOL: begin
            if (cool == '0)
               state_nxt = DS_RUN;
            else
               cool_nxt = cool - CDW'(1);
         end
         DS_DRAIN: begin
            if (count == '0)
               state_nxt = DS_DONE;
         end
         DS_DONE: begin
            program_done = !rst;
         end
      endcase
      if (eop && (state == DS_RUN || state == DS_COOL))
         state_nxt = DS_DRAIN;
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage.
// Expected entries queue on drive and pop on consume.
module tb_decode_stage;
   import proctypes::*;

   localparam int DEPTH = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   FetchAction     action;
   logic           instruction_valid = 1'b0;
   InstructionAddr pc_in = '0;
   Instruction     inst = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   InstructionAddr out_pc;
   logic [3:0]     out_opcode;
   logic [27:0]    out_operand;
   logic           program_done;
   logic           overflow_err;

   fifo_entry_t sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          pops = 0;
   bit          exp_ovf = 0;
   bit          eop_m = 0;
   FetchAction  act_seen;

   decode_stage #(
      .DEPTH    (DEPTH),
      .COOLDOWN (3)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .action            (action),
      .instruction_valid (instruction_valid),
      .pc_in             (pc_in),
      .inst              (inst),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_pc            (out_pc),
      .out_opcode        (out_opcode),
      .out_operand       (out_operand),
      .program_done      (program_done),
      .overflow_err      (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic cyc(input logic v,
                      input InstructionAddr p,
                      input Instruction i,
                      input logic r);
      bit pop_m;
      bit full_m;
      fifo_entry_t e;
      instruction_valid = v;
      pc_in = p;
      inst = i;
      out_ready = r;
      @(negedge clk);
      act_seen = action;
      chk("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
         chk("out_pc", out_pc, sb[0].pc);
         chk("out_opcode", out_opcode, sb[0].inst[31:28]);
         chk("out_operand", out_operand, sb[0].inst[27:0]);
      end
      chk("overflow_err", overflow_err, exp_ovf);
      if (action == fetchDequeue)
         chk("deq_gate", (sb.size() <= 4) && !eop_m, 1);
      pop_m = r && sb.size() != 0;
      full_m = sb.size() == DEPTH;
      if (pop_m) begin
         void'(sb.pop_front());
         pops++;
      end
      if (v && i != 0) begin
         if (!full_m || pop_m) begin
            e.pc = p;
            e.inst = i;
            sb.push_back(e);
         end else begin
            exp_ovf = 1;
         end
      end
      if (v && i == 0)
         eop_m = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic v);
      rst = 1'b1;
      instruction_valid = v;
      pc_in = 32'h99;
      inst = 32'h7000_0099;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_opcode", out_opcode, 0);
      chk("rst_operand", out_operand, 0);
      chk("rst_done", program_done, 0);
      chk("rst_ovf", overflow_err, 0);
      chk("rst_action", action, fetchHold);
      rst = 1'b0;
      instruction_valid = 1'b0;
      sb.delete();
      exp_ovf = 0;
      eop_m = 0;
      pops = 0;
   endtask

   task automatic idle_seq();
      FetchAction exp;
      for (int k = 1; k <= 9; k++) begin
         cyc(0, '0, '0, 0);
         exp = (k % 4 == 1) ? fetchDequeue : fetchHold;
         chk($sformatf("act_c%0d", k), act_seen, exp);
      end
   endtask

   initial begin
      int w;
      do_reset(0);
      idle_seq();

      cyc(1, 32'd5, 32'h3000_0012, 1);
      chk("r36_valid", out_valid, 1);
      chk("r36_opcode", out_opcode, 4'h3);
      chk("r36_operand", out_operand, 28'h12);
      chk("r36_pc", out_pc, 32'd5);
      cyc(0, '0, '0, 1);

      for (int k = 0; k < 24; k++)
         cyc(1'($urandom % 2), InstructionAddr'(100 + k),
             Instruction'($urandom | 32'h1),
             1'($urandom % 2));
      repeat (10) cyc(0, '0, '0, 1);

      do_reset(0);
      for (int k = 0; k < 8; k++)
         cyc(1, InstructionAddr'(16 + k),
             Instruction'({4'(k + 1), 28'(k * 3 + 1)}), 0);
      cyc(1, 32'd99, 32'hF000_0099, 0);
      repeat (2) cyc(0, '0, '0, 0);
      chk("r37_ovf", overflow_err, 1);
      chk("r37_head", out_pc, 32'd16);
      repeat (10) cyc(0, '0, '0, 1);
      chk("r37_pops", pops, 8);

      do_reset(0);
      for (int k = 0; k < 8; k++)
         cyc(1, InstructionAddr'(32 + k),
             Instruction'({4'(8 - k), 28'(k + 7)}), 0);
      cyc(1, 32'd40, 32'hA000_0040, 1);
      cyc(0, '0, '0, 0);
      chk("r38_ovf", overflow_err, 0);
      repeat (10) cyc(0, '0, '0, 1);
      chk("r38_pops", pops, 9);

      do_reset(0);
      cyc(1, 32'd0, 32'h1000_0001, 0);
      cyc(1, 32'd1, 32'h2000_0002, 0);
      cyc(1, 32'd2, 32'h0, 0);
      chk("r39_early", program_done, 0);
      w = 0;
      while (!program_done && w < 30) begin
         cyc(0, '0, '0, 1);
         w++;
      end
      chk("r39_done", program_done, 1);
      chk("r39_pops", pops, 2);
      repeat (8) begin
         cyc(0, '0, '0, 1);
         chk("r39_hold", program_done, 1);
         chk("r39_act", act_seen, fetchHold);
      end

      do_reset(0);
      for (int k = 0; k < 3; k++)
         cyc(1, InstructionAddr'(60 + k),
             Instruction'(32'h6000_0000 + k), 0);
      do_reset(1);
      idle_seq();
      cyc(1, 32'd7, 32'h5000_0007, 1);
      repeat (3) cyc(0, '0, '0, 1);
      chk("r40_pops", pops, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
